// File: rtl/riscv_defines.sv
// Shared type definitions for the integer datapath: ALU opcodes, divider
// opcodes and the sequential divider's FSM states.
package riscv_defines;

    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_XOR = 3'd5
    } alu_op_t;

    // Bit 0 set means unsigned, bit 1 set means remainder.
    typedef enum logic [1:0] {
        DIV  = 2'b00,
        DIVU = 2'b01,
        REM  = 2'b10,
        REMU = 2'b11
    } div_op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        NEG  = 3'd1,
        ITER = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/alu.sv
// Small combinational ALU shared by the datapath; the divider only ever
// asks it to subtract.
module alu
    import riscv_defines::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_t                 i_alu_op,
    input  logic [DATA_WIDTH-1:0]   i_a,
    input  logic [DATA_WIDTH-1:0]   i_b,
    output logic [DATA_WIDTH-1:0]   o_result
);

    always_comb begin
        o_result = '0;
        case (i_alu_op)
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU/REM/REMU) with fixed latency,
// special-case bypass and kill support; all arithmetic goes through one ALU.
module div_seq
    import riscv_defines::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  div_op_t                 i_op,
    input  logic [DATA_WIDTH-1:0]   i_dividend,
    input  logic [DATA_WIDTH-1:0]   i_divisor,
    input  logic                    i_kill,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_result,
    output logic                    o_busy
);

    div_state_t              state, next_state;
    logic [4:0]              count;
    logic [DATA_WIDTH-1:0]   rem, quo, dvs, result;
    logic                    is_rem, neg_a, neg_b, neg_res;

    alu_op_t                 alu_op;
    logic [DATA_WIDTH-1:0]   alu_a, alu_b, alu_res, diff;
    logic [DATA_WIDTH:0]     shifted;
    logic                    q_bit;

    logic                    accept, signed_op, div_zero, overflow, special;
    logic [DATA_WIDTH-1:0]   special_res;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .i_alu_op (alu_op),
        .i_a      (alu_a),
        .i_b      (alu_b),
        .o_result (alu_res)
    );

    always_comb begin
        accept      = i_valid && (state == IDLE) && !i_kill;
        signed_op   = !i_op[0];
        div_zero    = (i_divisor == '0);
        overflow    = signed_op && (i_dividend == {1'b1, {(DATA_WIDTH-1){1'b0}}})
                      && (i_divisor == '1);
        special     = div_zero || overflow;
        special_res = '0;
        if (div_zero)
            special_res = i_op[1] ? i_dividend : '1;
        else
            special_res = i_op[1] ? '0 : i_dividend;
    end

    // A negative divisor is kept as-is: s - |b| equals ~(~s - b), and
    // s >= |b| equals s > ~b, so only inverters are needed around the ALU.
    always_comb begin
        shifted = {rem, quo[DATA_WIDTH-1]};
        if (neg_b)
            q_bit = shifted[DATA_WIDTH] || (shifted[DATA_WIDTH-1:0] > ~dvs);
        else
            q_bit = shifted[DATA_WIDTH] || (shifted[DATA_WIDTH-1:0] >= dvs);
        diff = neg_b ? ~alu_res : alu_res;
    end

    always_comb begin
        alu_op = ALU_NOP;
        alu_a  = '0;
        alu_b  = '0;
        case (state)
            NEG: begin
                alu_op = ALU_SUB;
                alu_b  = quo;
            end
            ITER: begin
                alu_op = ALU_SUB;
                alu_a  = neg_b ? ~shifted[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
                alu_b  = dvs;
            end
            FIX: begin
                alu_op = ALU_SUB;
                alu_b  = is_rem ? rem : quo;
            end
            default: ;
        endcase
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = special ? DONE : NEG;
            NEG:  next_state = ITER;
            ITER: if (count == 5'd31) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (i_kill)
            next_state = IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            count   <= '0;
            rem     <= '0;
            quo     <= '0;
            dvs     <= '0;
            result  <= '0;
            is_rem  <= 1'b0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            neg_res <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: if (accept) begin
                    quo     <= i_dividend;
                    dvs     <= i_divisor;
                    rem     <= '0;
                    count   <= '0;
                    is_rem  <= i_op[1];
                    neg_a   <= signed_op && i_dividend[DATA_WIDTH-1];
                    neg_b   <= signed_op && i_divisor[DATA_WIDTH-1];
                    neg_res <= i_op[1] ? (signed_op && i_dividend[DATA_WIDTH-1])
                                       : (signed_op && (i_dividend[DATA_WIDTH-1]
                                                        ^ i_divisor[DATA_WIDTH-1]));
                    if (special)
                        result <= special_res;
                end
                NEG: if (neg_a) quo <= alu_res;
                ITER: begin
                    rem   <= q_bit ? diff : shifted[DATA_WIDTH-1:0];
                    quo   <= {quo[DATA_WIDTH-2:0], q_bit};
                    count <= count + 5'd1;
                end
                FIX: if (!i_kill) begin
                    if (neg_res)
                        result <= alu_res;
                    else
                        result <= is_rem ? rem : quo;
                end
                default: ;
            endcase
        end
    end

    assign o_ready  = (state == IDLE);
    assign o_busy   = (state != IDLE);
    assign o_valid  = (state == DONE);
    assign o_result = result;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: a table of operations with hand-computed results
// and latencies, then kill, held-request and reset sequences.
module tb_div_seq;
    import riscv_defines::*;

    logic          clk, rst, valid, kill;
    div_op_t       op;
    logic [31:0]   dividend, divisor;
    logic          ready, out_valid, busy;
    logic [31:0]   result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        div_op_t     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expected;
        int          latency;
    } vec_t;

    vec_t vecs[16];

    div_seq #(.DATA_WIDTH(32)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (valid),
        .o_ready    (ready),
        .i_op       (op),
        .i_dividend (dividend),
        .i_divisor  (divisor),
        .i_kill     (kill),
        .o_valid    (out_valid),
        .o_result   (result),
        .o_busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Issues one request from IDLE and reports the cycle o_valid rose in
    // (1 = first cycle after acceptance) plus the result seen there.
    task automatic applyStimulus(input string name, input div_op_t o,
                                 input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] res);
        @(negedge clk);
        valid = 1'b1; op = o; dividend = a; divisor = b;
        checkOutput({name, " ready"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
        valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        res = result;
    endtask

    initial begin
        int          lat;
        logic [31:0] res;
        logic        seen;

        vecs[0]  = '{"divu_100_7",    DIVU, 32'd100,        32'd7,          32'd14,         35};
        vecs[1]  = '{"remu_100_7",    REMU, 32'd100,        32'd7,          32'd2,          35};
        vecs[2]  = '{"div_m7_2",      DIV,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   35};
        vecs[3]  = '{"rem_m7_2",      REM,  32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   35};
        vecs[4]  = '{"rem_7_m2",      REM,  32'd7,          32'hFFFFFFFE,   32'd1,          35};
        vecs[5]  = '{"div_7_m2",      DIV,  32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   35};
        vecs[6]  = '{"div_m100_m7",   DIV,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         35};
        vecs[7]  = '{"rem_m100_m7",   REM,  32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   35};
        vecs[8]  = '{"divu_max_1",    DIVU, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   35};
        vecs[9]  = '{"remu_max_10",   REMU, 32'hFFFFFFFF,   32'd10,         32'd5,          35};
        vecs[10] = '{"div_min_1",     DIV,  32'h80000000,   32'd1,          32'h80000000,   35};
        vecs[11] = '{"divu_0_5",      DIVU, 32'd0,          32'd5,          32'd0,          35};
        vecs[12] = '{"divu_5_0",      DIVU, 32'd5,          32'd0,          32'hFFFFFFFF,   1};
        vecs[13] = '{"rem_5_0",       REM,  32'd5,          32'd0,          32'd5,          1};
        vecs[14] = '{"div_ovf",       DIV,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   1};
        vecs[15] = '{"rem_ovf",       REM,  32'h80000000,   32'hFFFFFFFF,   32'd0,          1};

        rst = 1'b1; valid = 1'b0; kill = 1'b0; op = DIVU; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset valid",  {31'd0, out_valid}, 32'd0);
        checkOutput("reset busy",   {31'd0, busy},      32'd0);
        checkOutput("reset ready",  {31'd0, ready},     32'd1);
        checkOutput("reset result", result,             32'd0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, lat, res);
            checkOutput({vecs[i].name, " result"}, res, vecs[i].expected);
            checkOutput({vecs[i].name, " latency"}, lat, vecs[i].latency);
            @(negedge clk);
            checkOutput({vecs[i].name, " pulse"}, {31'd0, out_valid}, 32'd0);
        end

        // Kill while the iteration counter is at 10.
        @(negedge clk);
        valid = 1'b1; op = DIVU; dividend = 32'd1000; divisor = 32'd3;
        @(negedge clk);
        valid = 1'b0;
        repeat (11) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        checkOutput("kill ready", {31'd0, ready},     32'd1);
        checkOutput("kill busy",  {31'd0, busy},      32'd0);
        seen = out_valid;
        repeat (40) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("kill no valid", {31'd0, seen}, 32'd0);
        applyStimulus("after_kill", DIVU, 32'd9, 32'd3, lat, res);
        checkOutput("after_kill result",  res, 32'd3);
        checkOutput("after_kill latency", lat, 32'd35);

        // Kill together with a request in IDLE rejects it.
        @(negedge clk);
        valid = 1'b1; kill = 1'b1; op = DIVU; dividend = 32'd8; divisor = 32'd2;
        @(negedge clk);
        valid = 1'b0; kill = 1'b0;
        checkOutput("kill_idle busy", {31'd0, busy}, 32'd0);

        // Request held high with changing operands while busy.
        @(negedge clk);
        valid = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        lat = 1;
        while (!out_valid && lat < 60) begin
            dividend = dividend + 32'd13;
            divisor  = divisor + 32'd1;
            @(negedge clk);
            lat++;
        end
        checkOutput("hold result",  result, 32'd14);
        checkOutput("hold latency", lat,    32'd35);
        dividend = 32'd50; divisor = 32'd5;
        @(negedge clk);
        checkOutput("hold ready after done", {31'd0, ready}, 32'd1);
        @(negedge clk);
        checkOutput("hold second accepted", {31'd0, busy}, 32'd1);
        valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("hold second result",  result, 32'd10);
        checkOutput("hold second latency", lat,    32'd35);

        // Reset while in FIX.
        @(negedge clk);
        valid = 1'b1; op = DIVU; dividend = 32'd100; divisor = 32'd7;
        @(negedge clk);
        valid = 1'b0;
        repeat (33) @(negedge clk);
        checkOutput("fix busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("fix_rst busy",   {31'd0, busy},      32'd0);
        checkOutput("fix_rst valid",  {31'd0, out_valid}, 32'd0);
        checkOutput("fix_rst result", result,             32'd0);
        checkOutput("fix_rst ready",  {31'd0, ready},     32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
